bus_generator_arbiter: RTL and testbench
========================================

BUS_GENERATOR_ARBITER -- requirements
Module: bus_generator_arbiter

Interface
REQ-001 Parameter bits, default 1: number of independent buses (lanes).
REQ-002 Parameter drvrs, default 4: number of devices attached to each bus.
REQ-003 Parameter pckg_sz, default 16: packet width; bits [pckg_sz-1 -: 8] hold the destination ID; pckg_sz SHALL be >= 9.
REQ-004 Parameter broadcast, default 8'hFF: destination ID meaning "all devices".
REQ-005 clk  input  1: single clock; all logic is rising-edge.
REQ-006 reset  input  1: asynchronous, active-low reset.
REQ-007 pndng  input  [bits-1:0][drvrs-1:0]: device FIFO has a packet pending.
REQ-008 D_pop  input  [bits-1:0][drvrs-1:0][pckg_sz-1:0]: head-of-FIFO data per device (first-word-fall-through, valid while pndng=1).
REQ-009 pop  output  [bits-1:0][drvrs-1:0]: one-cycle pulse dequeuing the granted device FIFO.
REQ-010 push  output  [bits-1:0][drvrs-1:0]: one-cycle pulse writing D_push into a device's receive FIFO.
REQ-011 D_push  output  [bits-1:0][pckg_sz-1:0]: packet driven on each bus, shared by all devices of that bus.

Function
REQ-012 Each lane SHALL operate independently with a 2-state FSM: IDLE and PUSH.
REQ-013 In IDLE with any pndng[lane] set, the lane SHALL grant one source by round-robin, searching from (last_grant+1) mod drvrs upward with wrap-around.
REQ-014 In the grant cycle, the lane SHALL pulse pop[lane][src] for exactly one cycle, latch D_pop[lane][src] and src, and go to PUSH.
REQ-015 In PUSH, the lane SHALL drive D_push[lane] = latched packet and pulse push[lane][dest] for one cycle, where dest = packet[pckg_sz-1 -: 8], then return to IDLE.
REQ-016 A broadcast destination SHALL pulse push on every device of the lane except src, in the same cycle.
REQ-017 A destination that is >= drvrs and not broadcast SHALL produce no push; the packet is dropped and the FSM still returns to IDLE.
REQ-018 A destination equal to src SHALL be delivered to src (loopback).
REQ-019 Latency: pop at edge N, push at edge N+1; throughput is one packet per 2 cycles per lane.
REQ-020 With no pndng set, the lane SHALL stay in IDLE with pop=0 and push=0.
REQ-021 D_push SHALL hold its last value outside PUSH; it is qualified only by push.
REQ-022 pndng changes during PUSH SHALL be ignored until the lane is back in IDLE.
REQ-023 last_grant SHALL update only on a grant.

Reset
REQ-024 While reset=0, every lane SHALL clear pop, push and D_push to 0, enter IDLE, and set last_grant=drvrs-1 so that device 0 has first priority.
REQ-025 Reset asserted mid-transfer SHALL abort the transfer: the latched packet is discarded and no push is issued after release.
REQ-026 The first grant SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the destination-field width constant (8), and the default broadcast constant.
REQ-028 One sub-module, bus_lane_arbiter, SHALL implement a single lane (FSM, round-robin pointer, packet latch).
REQ-029 The top SHALL instantiate bits copies of bus_lane_arbiter via a generate loop.

Verification
REQ-030 Single packet: device 1 pending with 16'h0255 -> pop[0][1] pulses at cycle N, then push[0][2] pulses at N+1 with D_push=16'h0255.
REQ-031 Broadcast: device 0 sends 16'hFF12 -> push[0] = 4'b1110 for one cycle with D_push=16'hFF12.
REQ-032 Fairness: devices 0..3 all pending continuously -> grant order 0,1,2,3,0 with no starvation.
REQ-033 Invalid destination: device 3 sends 16'h0701 -> pop[0][3] pulses, push stays 0, FSM returns to IDLE.
REQ-034 Reset mid-transfer: reset=0 in the PUSH cycle -> push, pop and D_push read 0; after release the next grant goes to device 0.
REQ-035 Multi-bus (bits=2): simultaneous traffic on both lanes -> each lane delivers its own packets independently and in the same cycles.

Source files
------------

// File: rtl/bus_generator_arbiter_pkg.sv
// Shared types and constants for the bus generator arbiter slice.
// Holds the per-lane FSM encoding and the destination-field width.
package bus_generator_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PUSH = 1'b1
    } lane_state_t;

    localparam int unsigned DEST_W       = 8;
    localparam logic [DEST_W-1:0] BROADCAST_ID = 8'hFF;

endpackage

// File: rtl/bus_generator_arbiter_lane.sv
// Single-lane arbiter: round-robin grant, packet latch and
// destination decode, with registered pop/push/D_push outputs.
module bus_lane_arbiter
    import bus_generator_arbiter_pkg::*;
#(
    parameter int unsigned       drvrs     = 4,
    parameter int unsigned       pckg_sz   = 16,
    parameter logic [DEST_W-1:0] broadcast = BROADCAST_ID
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   d_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              d_push
);

    localparam int unsigned SRC_W = (drvrs > 1) ? $clog2(drvrs) : 1;

    lane_state_t        state, state_nxt;
    logic [SRC_W-1:0]   last_grant, src, grant_idx, hi_idx, lo_idx;
    logic               hi_found, lo_found, grant_valid, do_grant;
    logic [pckg_sz-1:0] pkt;
    logic [drvrs-1:0]   pop_nxt, push_nxt;
    logic [DEST_W-1:0]  dest;

    assign dest     = pkt[pckg_sz-1 -: DEST_W];
    assign do_grant = (state == ST_IDLE) && grant_valid;

    // Round-robin: lowest pending index above last_grant wins, else wrap to lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned j = 0; j < drvrs; j++) begin
            if (pndng[j] && (j > 32'(last_grant)) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = SRC_W'(j);
            end
            if (pndng[j] && (j <= 32'(last_grant)) && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = SRC_W'(j);
            end
        end
        grant_valid = hi_found || lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_valid) state_nxt = ST_PUSH;
            ST_PUSH: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pop_nxt  = '0;
        push_nxt = '0;
        if (do_grant) pop_nxt[grant_idx] = 1'b1;
        if (state == ST_PUSH) begin
            if (dest == broadcast) begin
                push_nxt      = '1;
                push_nxt[src] = 1'b0;
            end else begin
                for (int unsigned j = 0; j < drvrs; j++) begin
                    if (dest == DEST_W'(j)) push_nxt[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop        <= '0;
            push       <= '0;
            d_push     <= '0;
            pkt        <= '0;
            src        <= '0;
            last_grant <= SRC_W'(drvrs - 1);
        end else begin
            pop  <= pop_nxt;
            push <= push_nxt;
            if (do_grant) begin
                pkt        <= d_pop[grant_idx];
                src        <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == ST_PUSH) d_push <= pkt;
        end
    end

endmodule

// File: rtl/bus_generator_arbiter.sv
// Multi-bus packet arbiter: one independent bus_lane_arbiter per lane.
module bus_generator_arbiter
    import bus_generator_arbiter_pkg::*;
#(
    parameter int unsigned       bits      = 1,
    parameter int unsigned       drvrs     = 4,
    parameter int unsigned       pckg_sz   = 16,
    parameter logic [DEST_W-1:0] broadcast = BROADCAST_ID
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [bits-1:0][drvrs-1:0]               pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
    output logic [bits-1:0][drvrs-1:0]               pop,
    output logic [bits-1:0][drvrs-1:0]               push,
    output logic [bits-1:0][pckg_sz-1:0]             D_push
);

    for (genvar g = 0; g < int'(bits); g++) begin : g_lane
        bus_lane_arbiter #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .pndng  (pndng[g]),
            .d_pop  (D_pop[g]),
            .pop    (pop[g]),
            .push   (push[g]),
            .d_push (D_push[g])
        );
    end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Directed bench for bus_generator_arbiter with two lanes of four devices.
module tb_bus_generator_arbiter;

    logic                   clk;
    logic                   reset;
    logic [1:0][3:0]        pndng;
    logic [1:0][3:0][15:0]  d_pop;
    logic [1:0][3:0]        pop;
    logic [1:0][3:0]        push;
    logic [1:0][15:0]       d_push;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]       pn;
        logic [3:0][15:0] d;
        logic [3:0]       pop;
        logic [3:0]       push;
        logic [15:0]      dpush;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    bus_generator_arbiter #(
        .bits      (2),
        .drvrs     (4),
        .pckg_sz   (16),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (d_pop),
        .pop    (pop),
        .push   (push),
        .D_push (d_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [3:0] pn, input logic [15:0] d0, input logic [15:0] d1,
                               input logic [15:0] d2, input logic [15:0] d3, input logic [3:0] p,
                               input logic [3:0] q, input logic [15:0] dp);
        vec_t r;
        r.pn    = pn;
        r.d     = {d3, d2, d1, d0};
        r.pop   = p;
        r.push  = q;
        r.dpush = dp;
        return r;
    endfunction

    initial begin
        // idle, single packet, broadcast
        tbl[0]  = v(4'b0000, 16'h0, 16'h0,    16'h0, 16'h0, 4'b0000, 4'b0000, 16'h0000);
        tbl[1]  = v(4'b0010, 16'h0, 16'h0255, 16'h0, 16'h0, 4'b0010, 4'b0000, 16'h0000);
        tbl[2]  = v(4'b0000, 16'h0, 16'h0,    16'h0, 16'h0, 4'b0000, 4'b0100, 16'h0255);
        tbl[3]  = v(4'b0001, 16'hFF12, 16'h0, 16'h0, 16'h0, 4'b0001, 4'b0000, 16'h0255);
        tbl[4]  = v(4'b0000, 16'h0, 16'h0,    16'h0, 16'h0, 4'b0000, 4'b1110, 16'hFF12);
        // fairness with everybody pending (last grant was 0)
        tbl[5]  = v(4'b1111, 16'h0300, 16'h0011, 16'h0122, 16'h0233, 4'b0010, 4'b0000, 16'hFF12);
        tbl[6]  = v(4'b1111, 16'h0300, 16'h0011, 16'h0122, 16'h0233, 4'b0000, 4'b0001, 16'h0011);
        tbl[7]  = v(4'b1111, 16'h0300, 16'h0011, 16'h0122, 16'h0233, 4'b0100, 4'b0000, 16'h0011);
        tbl[8]  = v(4'b1111, 16'h0300, 16'h0011, 16'h0122, 16'h0233, 4'b0000, 4'b0010, 16'h0122);
        tbl[9]  = v(4'b1111, 16'h0300, 16'h0011, 16'h0122, 16'h0233, 4'b1000, 4'b0000, 16'h0122);
        tbl[10] = v(4'b1111, 16'h0300, 16'h0011, 16'h0122, 16'h0233, 4'b0000, 4'b0100, 16'h0233);
        tbl[11] = v(4'b1111, 16'h0300, 16'h0011, 16'h0122, 16'h0233, 4'b0001, 4'b0000, 16'h0233);
        tbl[12] = v(4'b1111, 16'h0300, 16'h0011, 16'h0122, 16'h0233, 4'b0000, 4'b1000, 16'h0300);
        tbl[13] = v(4'b1111, 16'h0300, 16'h0011, 16'h0122, 16'h0233, 4'b0010, 4'b0000, 16'h0300);
        tbl[14] = v(4'b1111, 16'h0300, 16'h0011, 16'h0122, 16'h0233, 4'b0000, 4'b0001, 16'h0011);
        // invalid destination, then idle, then loopback
        tbl[15] = v(4'b1000, 16'h0, 16'h0, 16'h0, 16'h0701, 4'b1000, 4'b0000, 16'h0011);
        tbl[16] = v(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0,    4'b0000, 4'b0000, 16'h0701);
        tbl[17] = v(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0,    4'b0000, 4'b0000, 16'h0701);
        tbl[18] = v(4'b0100, 16'h0, 16'h0, 16'h0222, 16'h0, 4'b0100, 4'b0000, 16'h0701);
        tbl[19] = v(4'b0000, 16'h0, 16'h0, 16'h0,    16'h0, 4'b0000, 4'b0100, 16'h0222);

        reset = 1'b1;
        pndng = '0;
        d_pop = '0;
        #2 reset = 1'b0;
        tick();
        chk("reset_outputs", {pop, push, d_push}, 64'h0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            pndng[0] = tbl[i].pn;
            d_pop[0] = tbl[i].d;
            pndng[1] = '0;
            tick();
            chk($sformatf("vec%0d_lane0", i), {pop[0], push[0], d_push[0]},
                {tbl[i].pop, tbl[i].push, tbl[i].dpush});
            chk($sformatf("vec%0d_lane1_quiet", i), {pop[1], push[1], d_push[1]}, 64'h0);
        end

        // Reset during PUSH: transfer aborted, priority back to device 0
        pndng[0] = 4'b0100;
        d_pop[0] = {16'h0, 16'h0155, 16'h0, 16'h0};
        tick();
        chk("abort_grant_pop", {pop[0], push[0]}, {4'b0100, 4'b0000});
        reset = 1'b0;
        #1;
        chk("abort_async_clear", {pop[0], push[0], d_push[0]}, 64'h0);
        tick();
        chk("abort_held_clear", {pop[0], push[0], d_push[0]}, 64'h0);
        reset = 1'b1;
        pndng[0] = 4'b1111;
        d_pop[0] = {16'h0233, 16'h0122, 16'h0011, 16'h0300};
        tick();
        chk("post_reset_grant_dev0", {pop[0], push[0], d_push[0]}, {4'b0001, 4'b0000, 16'h0000});
        pndng[0] = 4'b0000;
        tick();
        chk("post_reset_push", {pop[0], push[0], d_push[0]}, {4'b0000, 4'b1000, 16'h0300});

        // Both lanes in the same cycles
        pndng[0] = 4'b0010;
        d_pop[0] = {16'h0, 16'h0, 16'h0355, 16'h0};
        pndng[1] = 4'b0100;
        d_pop[1] = {16'h0, 16'h0066, 16'h0, 16'h0};
        tick();
        chk("multi_lane0_pop", {pop[0], push[0]}, {4'b0010, 4'b0000});
        chk("multi_lane1_pop", {pop[1], push[1]}, {4'b0100, 4'b0000});
        pndng = '0;
        tick();
        chk("multi_lane0_push", {pop[0], push[0], d_push[0]}, {4'b0000, 4'b1000, 16'h0355});
        chk("multi_lane1_push", {pop[1], push[1], d_push[1]}, {4'b0000, 4'b0001, 16'h0066});
        tick();
        chk("multi_idle", {pop, push}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
